// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared types and encodings for the multicycle MIPS control FSM
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB,
    S_JUMP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - maps the controller state to its Moore control word
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output logic       iord_o,
  output logic       irwrite_o,
  output logic       memwrite_o,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] aluop_o,
  output logic [1:0] pcsrc_o,
  output logic       pcwrite_o,
  output logic       branch_o
);

  state_e st;
  assign st = state_e'(state_i);

  always_comb begin
    iord_o     = 1'b0;
    irwrite_o  = 1'b0;
    memwrite_o = 1'b0;
    regwrite_o = 1'b0;
    regdst_o   = 1'b0;
    memtoreg_o = 1'b0;
    alusrca_o  = 1'b0;
    alusrcb_o  = SRCB_B;
    aluop_o    = ALUOP_ADD;
    pcsrc_o    = PCSRC_ALU;
    pcwrite_o  = 1'b0;
    branch_o   = 1'b0;
    case (st)
      S_FETCH: begin
        // IR load and PC+4 only commit once the instruction word has arrived
        alusrcb_o = SRCB_FOUR;
        irwrite_o = mem_ready_i;
        pcwrite_o = mem_ready_i;
      end
      S_DECODE: alusrcb_o = SRCB_IMM_SH2;
      S_MEMADR: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
      end
      S_MEMRD: iord_o = 1'b1;
      S_MEMWB: begin
        memtoreg_o = 1'b1;
        regwrite_o = 1'b1;
      end
      S_MEMWR: begin
        iord_o     = 1'b1;
        memwrite_o = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst_o   = 1'b1;
        regwrite_o = 1'b1;
      end
      S_BRANCH: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_SUB;
        pcsrc_o   = PCSRC_ALUOUT;
        branch_o  = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
      end
      S_ADDIWB: regwrite_o = 1'b1;
      S_JUMP: begin
        pcsrc_o   = PCSRC_JUMP;
        pcwrite_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM with retired-instruction counter
module mc_controller
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;
  logic             irwrite_w, memwrite_w, regwrite_w, pcwrite_w, branch_w;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Every return to FETCH retires an instruction except the DECODE bail-out on a bad opcode
  assign retire  = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_DECODE);
  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  mc_output_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .iord_o      (iord),
    .irwrite_o   (irwrite_w),
    .memwrite_o  (memwrite_w),
    .regwrite_o  (regwrite_w),
    .regdst_o    (regdst),
    .memtoreg_o  (memtoreg),
    .alusrca_o   (alusrca),
    .alusrcb_o   (alusrcb),
    .aluop_o     (aluop),
    .pcsrc_o     (pcsrc),
    .pcwrite_o   (pcwrite_w),
    .branch_o    (branch_w)
  );

  // State-changing strobes are masked while reset is held so nothing commits mid-reset
  assign irwrite     = irwrite_w & reset_n;
  assign memwrite    = memwrite_w & reset_n;
  assign regwrite    = regwrite_w & reset_n;
  assign pcen        = (pcwrite_w | (branch_w & zero)) & reset_n;
  assign illegal_op  = (state_q == S_DECODE) && !op_is_legal(op) && reset_n;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed vector table plus randomized instruction stream against a phase model
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n, zero, mem_ready;
  logic [5:0] op;
  logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] instr_count;

  always #5 clk = ~clk;

  mc_controller #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  typedef enum {P_IF, P_ID, P_MA, P_MR, P_MW, P_MS, P_EX, P_AW, P_BR, P_AE, P_AB, P_JP} ph_e;
  typedef struct {
    logic       rstn;
    logic [5:0] op;
    logic       z;
    logic       mr;
    ph_e        ph;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   failed = 0;
  int   model_cnt = 0;

  logic [14:0] act;
  assign act = {iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, aluop, pcsrc, pcen, illegal_op};

  function automatic logic [14:0] mk(input logic io, irw, mw, rw, rd, m2r, asa,
                                     input logic [1:0] asb, aop, psrc, input logic pe, ill);
    return {io, irw, mw, rw, rd, m2r, asa, asb, aop, psrc, pe, ill};
  endfunction

  function automatic logic [14:0] ctl(input ph_e ph, input logic [5:0] o, input logic z,
                                      input logic mr, input logic rstn);
    logic [14:0] v;
    logic        legal;
    legal = o inside {LW, SW, RT, BEQ, ADDI, J};
    case (ph)
      P_IF:    v = mk(0, mr, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, mr, 0);
      P_ID:    v = mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, !legal);
      P_MA:    v = mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
      P_MR:    v = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      P_MW:    v = mk(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      P_MS:    v = mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      P_EX:    v = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
      P_AW:    v = mk(0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      P_BR:    v = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, z, 0);
      P_AE:    v = mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
      P_AB:    v = mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      default: v = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
    endcase
    if (!rstn) begin
      v[13] = 1'b0; v[12] = 1'b0; v[11] = 1'b0; v[1] = 1'b0; v[0] = 1'b0;
    end
    return v;
  endfunction

  task automatic add(input logic rstn, input logic [5:0] o, input logic z, input logic mr,
                     input ph_e ph, input logic [3:0] cnt);
    vec_t r;
    r.rstn = rstn; r.op = o; r.z = z; r.mr = mr; r.ph = ph; r.cnt = cnt;
    vecs.push_back(r);
  endtask

  task automatic check_cnt(input string name, input logic [3:0] exp);
    tests++;
    if (instr_count !== exp) begin
      failed++;
      $display("FAIL %s: instr_count=%0d expected %0d", name, instr_count, exp);
    end
  endtask

  task automatic step(input logic rstn, input logic [5:0] o, input logic z, input logic mr,
                      input ph_e ph, input logic [3:0] ecnt, input string name);
    logic [14:0] exp;
    @(negedge clk);
    reset_n = rstn; op = o; zero = z; mem_ready = mr;
    #1;
    exp = ctl(ph, o, z, mr, rstn);
    tests++;
    if (act !== exp || instr_count !== ecnt) begin
      failed++;
      $display("FAIL %s (%s): ctrl=%b cnt=%0d expected ctrl=%b cnt=%0d",
               name, ph.name(), act, instr_count, exp, ecnt);
    end
    @(posedge clk);
  endtask

  task automatic wait_phase(input logic [5:0] o, input ph_e ph);
    int   w;
    logic mr;
    w = 0;
    do begin
      mr = (w >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'b1, o, 1'($urandom_range(0, 1)), mr, ph, 4'(model_cnt), "rnd_wait");
      w++;
    end while (!mr);
  endtask

  // Model: an instruction is a fixed list of phases from its opcode; memory phases stretch on mem_ready
  task automatic run_instr(input logic [5:0] o);
    ph_e seq[$];
    wait_phase(o, P_IF);
    step(1'b1, o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), P_ID, 4'(model_cnt), "rnd_decode");
    case (o)
      LW:      seq = '{P_MA, P_MR, P_MW};
      SW:      seq = '{P_MA, P_MS};
      RT:      seq = '{P_EX, P_AW};
      BEQ:     seq = '{P_BR};
      ADDI:    seq = '{P_AE, P_AB};
      J:       seq = '{P_JP};
      default: seq = {};
    endcase
    if (seq.size() == 0) return;
    foreach (seq[k]) begin
      if (seq[k] == P_MR || seq[k] == P_MS) wait_phase(o, seq[k]);
      else step(1'b1, o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), seq[k],
                4'(model_cnt), "rnd_phase");
    end
    model_cnt++;
  endtask

  initial begin
    logic [5:0] ro;
    reset_n = 1'b0; op = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    add(1, LW, 0, 1, P_IF, 0);  add(1, LW, 0, 1, P_ID, 0);  add(1, LW, 0, 1, P_MA, 0);
    add(1, LW, 0, 1, P_MR, 0);  add(1, LW, 0, 1, P_MW, 0);
    add(1, SW, 0, 1, P_IF, 1);  add(1, SW, 0, 1, P_ID, 1);  add(1, SW, 0, 1, P_MA, 1);
    add(1, SW, 0, 0, P_MS, 1);  add(1, SW, 0, 0, P_MS, 1);  add(1, SW, 0, 0, P_MS, 1);
    add(1, SW, 0, 1, P_MS, 1);
    add(1, BEQ, 1, 1, P_IF, 2); add(1, BEQ, 1, 1, P_ID, 2); add(1, BEQ, 1, 1, P_BR, 2);
    add(1, BEQ, 0, 1, P_IF, 3); add(1, BEQ, 0, 1, P_ID, 3); add(1, BEQ, 0, 1, P_BR, 3);
    add(1, BAD, 0, 1, P_IF, 4); add(1, BAD, 0, 1, P_ID, 4);
    add(1, RT, 0, 0, P_IF, 4);  add(1, RT, 0, 1, P_IF, 4);  add(1, RT, 0, 1, P_ID, 4);
    add(1, RT, 0, 1, P_EX, 4);  add(1, RT, 0, 1, P_AW, 4);
    add(1, ADDI, 0, 1, P_IF, 5); add(1, ADDI, 0, 1, P_ID, 5); add(1, ADDI, 0, 1, P_AE, 5);
    add(1, ADDI, 0, 1, P_AB, 5);
    add(1, J, 0, 1, P_IF, 6);   add(1, J, 0, 1, P_ID, 6);   add(1, J, 0, 1, P_JP, 6);
    add(1, LW, 0, 1, P_IF, 7);  add(1, LW, 0, 1, P_ID, 7);  add(1, LW, 0, 1, P_MA, 7);
    add(1, LW, 0, 0, P_MR, 7);  add(0, LW, 0, 0, P_MR, 7);
    add(1, SW, 0, 1, P_IF, 0);  add(1, SW, 0, 1, P_ID, 0);  add(1, SW, 0, 1, P_MA, 0);
    add(0, SW, 0, 0, P_MS, 0);
    add(1, J, 0, 1, P_IF, 0);   add(1, J, 0, 1, P_ID, 0);   add(1, J, 0, 1, P_JP, 0);
    add(0, J, 0, 1, P_IF, 1);   add(1, J, 0, 0, P_IF, 0);

    foreach (vecs[i])
      step(vecs[i].rstn, vecs[i].op, vecs[i].z, vecs[i].mr, vecs[i].ph, vecs[i].cnt,
           $sformatf("vec%0d", i));

    model_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 6))
        0: ro = LW;
        1: ro = SW;
        2: ro = RT;
        3: ro = BEQ;
        4: ro = ADDI;
        5: ro = J;
        default: begin
          do ro = 6'($urandom); while (ro inside {LW, SW, RT, BEQ, ADDI, J});
        end
      endcase
      run_instr(ro);
    end

    while (model_cnt % 16 != 15) run_instr(J);
    #1;
    check_cnt("wrap_all_ones", 4'd15);
    run_instr(J);
    #1;
    check_cnt("wrap_to_zero", 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 op  in  6  opcode field of the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory has completed the current read or write this cycle.
REQ-008 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 irwrite  out  1  instruction-register load enable.
REQ-010 memwrite  out  1  memory write strobe.
REQ-011 regwrite  out  1  register-file write enable.
REQ-012 regdst  out  1  write-register select: 1 = rd, 0 = rt.
REQ-013 memtoreg  out  1  write-data select: 1 = MDR, 0 = ALUOut.
REQ-014 alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 alusrcb  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2.
REQ-016 aluop  out  2  to alu_decoder: 00 = add, 01 = sub, 10 = funct-decoded.
REQ-017 pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-018 pcen  out  1  PC load enable = pcwrite OR (branch AND zero).
REQ-019 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-020 instr_count  out  CNT_W  count of retired instructions.

Function
REQ-021 Moore FSM; outputs SHALL decode from the state only, except pcen, which also uses zero. Any output not listed for a state SHALL be 0.
REQ-022 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-023 FETCH: alusrcb=01; irwrite and internal pcwrite=1 only when mem_ready=1. The FSM SHALL hold in FETCH while mem_ready=0, then go to DECODE.
REQ-024 DECODE: alusrcb=11. Next state by op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXECUTE
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEXEC
- 000010 (j) -> JUMP
- any other op -> FETCH, with illegal_op=1 for that cycle.
REQ-025 MEMADR: alusrca=1, alusrcb=10. Next state: MEMRD if lw, MEMWR if sw.
REQ-026 MEMRD: iord=1; hold until mem_ready=1, then go to MEMWB.
REQ-027 MEMWB: memtoreg=1, regwrite=1; then FETCH.
REQ-028 MEMWR: iord=1, memwrite=1, asserted continuously while waiting; on mem_ready=1 go to FETCH.
REQ-029 EXECUTE: alusrca=1, aluop=10; then ALUWB.
REQ-030 ALUWB: regdst=1, regwrite=1; then FETCH.
REQ-031 BRANCH: alusrca=1, aluop=01, pcsrc=01, internal branch=1; then FETCH. pcen=zero in this state.
REQ-032 ADDIEXEC: alusrca=1, alusrcb=10; then ADDIWB.
REQ-033 ADDIWB: regwrite=1; then FETCH.
REQ-034 JUMP: pcsrc=10, pcwrite=1; then FETCH.
REQ-035 instr_count SHALL increment by 1, wrapping modulo 2^CNT_W, on each transition into FETCH from MEMWB, MEMWR (on mem_ready), ALUWB, BRANCH, ADDIWB or JUMP. An illegal-op return to FETCH SHALL NOT count.
REQ-036 Latency in cycles, with mem_ready=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-037 reset_n=0 at a clock edge SHALL set state=FETCH and instr_count=0 regardless of current state, including mid-wait in MEMRD or MEMWR.
REQ-038 While reset_n=0, irwrite, memwrite, regwrite, pcen and illegal_op SHALL be forced to 0.

Structure
REQ-039 Package mips_mc_pkg SHALL hold the state enum, opcode constants, aluop codes, and alusrcb and pcsrc encodings.
REQ-040 Sub-module mc_output_decode SHALL map state to the control word; the state register, next-state logic and counter SHALL live in mc_controller.

Verification
REQ-041 Reset then op=100011 with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 in cycle 5; instr_count=1.
REQ-042 op=101011 with mem_ready low for 3 cycles in MEMWR -> memwrite held high for 4 cycles, then FETCH; regwrite never 1.
REQ-043 op=000100: zero=1 -> pcen=1 in BRANCH; zero=0 -> pcen=0; both cases increment instr_count.
REQ-044 op=111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH; instr_count unchanged.
REQ-045 reset_n=0 for one edge while in MEMRD -> FETCH next cycle, instr_count=0, all write enables 0.
REQ-046 Preload instr_count to all-ones (CNT_W=4: 15), retire op=000010 -> instr_count=0.
